// File: rtl/sigma_mean_acc.sv
// Weighted-mean accumulator: sums W_i*X_i per state element over a two-lane
// sigma-point stream, then streams out the saturated mean vector.
module sigma_mean_acc #(
    parameter int unsigned N_STATE   = 6,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned W_FRAC    = 30,
    parameter int unsigned ACC_GUARD = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [DATA_W-1:0]          w0m,
    input  logic [DATA_W-1:0]          w,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_a,
    input  logic [DATA_W-1:0]          in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(N_STATE)-1:0] out_idx,
    output logic                       busy,
    output logic                       done
);
    localparam int unsigned ACC_W = DATA_W + ACC_GUARD;
    localparam int unsigned IDX_W = $clog2(N_STATE);
    localparam int unsigned K_W   = $clog2(N_STATE + 1);
    // Product is formed wide enough that bits [W_FRAC +: ACC_W] are the
    // floor-shifted term already sign-extended to the accumulator width.
    localparam int unsigned P_W   = (2 * DATA_W > W_FRAC + ACC_W) ? 2 * DATA_W : W_FRAC + ACC_W;
    localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N_STATE - 1);
    localparam logic [K_W-1:0]   K_LAST = K_W'(N_STATE);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    state_t                  state_q;
    logic [DATA_W-1:0]       wr0_q;
    logic [DATA_W-1:0]       wr_q;
    logic [K_W-1:0]          k_q;
    logic [IDX_W-1:0]        j_q;
    logic                    done_q;
    logic signed [ACC_W-1:0] acc_q [N_STATE];

    logic [DATA_W-1:0]       wk;
    logic signed [P_W-1:0]   prod_a;
    logic signed [P_W-1:0]   prod_b;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_sel;
    logic [ACC_W-DATA_W:0]   acc_hi;
    logic                    unused_prod;

    always_comb begin
        wk     = (k_q == '0) ? wr0_q : wr_q;
        prod_a = $signed({{(P_W-DATA_W){in_a[DATA_W-1]}}, in_a})
               * $signed({{(P_W-DATA_W){wk[DATA_W-1]}}, wk});
        prod_b = $signed({{(P_W-DATA_W){in_b[DATA_W-1]}}, in_b})
               * $signed({{(P_W-DATA_W){wk[DATA_W-1]}}, wk});
        acc_d  = acc_q[j_q] + prod_a[W_FRAC +: ACC_W] + prod_b[W_FRAC +: ACC_W];
    end

    assign unused_prod = ^{prod_a, prod_b};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            wr0_q   <= '0;
            wr_q    <= '0;
            k_q     <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < N_STATE; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        wr0_q   <= w0m;
                        wr_q    <= w;
                        k_q     <= '0;
                        j_q     <= '0;
                        state_q <= S_ACCUM;
                        for (int unsigned i = 0; i < N_STATE; i++) begin
                            acc_q[i] <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc_q[j_q] <= acc_d;
                        if (j_q == J_LAST) begin
                            j_q <= '0;
                            if (k_q == K_LAST) begin
                                state_q <= S_DRAIN;
                            end else begin
                                k_q <= k_q + 1'b1;
                            end
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (j_q == J_LAST) begin
                            j_q     <= '0;
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Saturate when the guard bits and the DATA_W sign bit disagree.
    always_comb begin
        acc_sel = acc_q[j_q];
        acc_hi  = acc_sel[ACC_W-1:DATA_W-1];
        if (state_q != S_DRAIN) begin
            out_data = '0;
        end else if ((&acc_hi) || !(|acc_hi)) begin
            out_data = acc_sel[DATA_W-1:0];
        end else if (acc_sel[ACC_W-1]) begin
            out_data = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            out_data = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DRAIN);
    assign out_idx   = (state_q == S_DRAIN) ? j_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_sigma_mean_acc.sv
// Bench for sigma_mean_acc: directed runs with random samples and handshake
// stalls, checked against an arithmetic model of the weighted mean.
module tb_sigma_mean_acc;
    localparam int N  = 6;
    localparam int NP = N + 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] w0m;
    logic [31:0] w;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_idx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sa [NP][N];
    logic [31:0] sb [NP][N];
    logic [31:0] exp_mean [N];

    sigma_mean_acc #(
        .N_STATE  (N),
        .DATA_W   (32),
        .W_FRAC   (30),
        .ACC_GUARD(4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .w0m      (w0m),
        .w        (w),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // floor(x*w / 2^30) with both operands signed
    function automatic longint term(input logic [31:0] x, input logic [31:0] wt);
        longint p;
        p = longint'($signed(x)) * longint'($signed(wt));
        return p >>> 30;
    endfunction

    function automatic void compute_expected(input logic [31:0] w0, input logic [31:0] w1);
        longint s;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < NP; k++) begin
                s += term(sa[k][j], (k == 0) ? w0 : w1) + term(sb[k][j], (k == 0) ? w0 : w1);
            end
            s = (s <<< 28) >>> 28;
            if (s > 64'sd2147483647)       exp_mean[j] = 32'h7FFF_FFFF;
            else if (s < -64'sd2147483648) exp_mean[j] = 32'h8000_0000;
            else                           exp_mean[j] = s[31:0];
        end
    endfunction

    function automatic void fill(input logic [31:0] v, input bit rnd);
        for (int k = 0; k < NP; k++) begin
            for (int j = 0; j < N; j++) begin
                sa[k][j] = rnd ? $urandom : v;
                sb[k][j] = rnd ? $urandom : v;
            end
        end
    endfunction

    task automatic check_idle_outputs(input string name);
        check($sformatf("%s/in_ready", name),  in_ready,  0);
        check($sformatf("%s/out_valid", name), out_valid, 0);
        check($sformatf("%s/out_data", name),  out_data,  0);
        check($sformatf("%s/out_idx", name),   out_idx,   0);
        check($sformatf("%s/busy", name),      busy,      0);
        check($sformatf("%s/done", name),      done,      0);
    endtask

    task automatic run(input string name, input logic [31:0] w0, input logic [31:0] w1,
                       input int vprob, input int rprob, input bit poke_start, input int reset_after);
        int acc_n;
        int e;
        int budget;
        bit take;
        compute_expected(w0, w1);
        @(negedge clk);
        start = 1'b1;
        w0m   = w0;
        w     = w1;
        @(negedge clk);
        start = 1'b0;
        w0m   = $urandom;
        w     = $urandom;
        check($sformatf("%s/busy_after_start", name), busy, 1);
        check($sformatf("%s/ready_after_start", name), in_ready, 1);

        acc_n  = 0;
        budget = 0;
        while (acc_n < NP * N && budget < 2000) begin
            if (reset_after >= 0 && acc_n == reset_after) break;
            budget++;
            in_valid = ($urandom_range(99) < vprob);
            in_a     = sa[acc_n / N][acc_n % N];
            in_b     = sb[acc_n / N][acc_n % N];
            start    = poke_start && (acc_n == 20);
            if (start) begin
                w0m = $urandom;
                w   = $urandom;
            end
            take = in_valid && in_ready;
            @(negedge clk);
            start = 1'b0;
            if (take) acc_n++;
        end
        in_valid = 1'b0;

        if (reset_after >= 0) begin
            check($sformatf("%s/beats_before_reset", name), acc_n, reset_after);
            rstn = 1'b0;
            #1;
            check_idle_outputs($sformatf("%s/in_reset", name));
            @(negedge clk);
            rstn = 1'b1;
            @(negedge clk);
            check_idle_outputs($sformatf("%s/after_reset", name));
            return;
        end

        check($sformatf("%s/beats_accepted", name), acc_n, NP * N);
        check($sformatf("%s/ready_drop", name), in_ready, 0);

        e      = 0;
        budget = 0;
        while (e < N && budget < 2000) begin
            budget++;
            out_ready = ($urandom_range(99) < rprob);
            check($sformatf("%s/out_valid[%0d]", name, e), out_valid, 1);
            check($sformatf("%s/out_idx[%0d]", name, e),   out_idx,   e);
            check($sformatf("%s/out_data[%0d]", name, e),  out_data,  exp_mean[e]);
            check($sformatf("%s/no_early_done[%0d]", name, e), done, 0);
            take = out_valid && out_ready;
            @(negedge clk);
            if (take) e++;
        end
        out_ready = 1'b0;
        check($sformatf("%s/outputs_drained", name), e, N);
        check($sformatf("%s/done_pulse", name), done, 1);
        check($sformatf("%s/busy_clear", name), busy, 0);
        check($sformatf("%s/valid_clear", name), out_valid, 0);
        @(negedge clk);
        check($sformatf("%s/done_single", name), done, 0);
    endtask

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        w0m       = '0;
        w         = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rstn = 1'b1;

        fill(32'h0001_0000, 1'b0);
        run("uniform", 32'h0000_0000, 32'h0AAA_AAAB, 100, 100, 1'b0, -1);

        fill(32'h7FFF_0000, 1'b0);
        for (int j = 0; j < N; j++) begin
            sa[0][j] = 32'h0002_0000;
            sb[0][j] = 32'h0002_0000;
        end
        run("center", 32'h2000_0000, 32'h0000_0000, 100, 100, 1'b0, -1);

        fill('0, 1'b1);
        for (int j = 0; j < N; j++) begin
            sa[0][j] = 32'h0003_0000;
            sb[0][j] = 32'h0003_0000;
        end
        run("neg_stall", 32'hE000_0000, 32'h0000_0000, 55, 45, 1'b0, -1);

        fill(32'h7FFF_0000, 1'b0);
        run("sat_pos", 32'h4000_0000, 32'h4000_0000, 100, 100, 1'b0, -1);
        fill(32'h8000_0000, 1'b0);
        run("sat_neg", 32'h4000_0000, 32'h4000_0000, 100, 100, 1'b0, -1);

        fill('0, 1'b1);
        run("mid_reset", $urandom, $urandom, 70, 100, 1'b0, 10);

        fill('0, 1'b1);
        run("post_reset", $urandom, $urandom, 80, 70, 1'b0, -1);

        fill('0, 1'b1);
        run("busy_start", $urandom, $urandom, 85, 85, 1'b1, -1);

        fill('0, 1'b1);
        run("random", $urandom, $urandom, 65, 60, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
